// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS-subset core: byte IMEM, 32x32 register file, ALU, byte DMEM; the PC lives outside.
// Latency: fetch/decode/ALU combinational; RF writes on falling clk, DMEM stores on rising clk.
// Backpressure: none; one instruction per cycle, status outputs always decode the current fetch.

// Instruction store, big-endian word fetch with byte-index wrap; load port exists only for preload.
module mips_imem #(
    parameter int BYTES = 256
) (
    input  logic        clk,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_dat,
    input  logic [7:0]  addr,
    output logic [31:0] instr
);
    logic [7:0] IM [0:BYTES-1];
    logic [7:0] a1, a2, a3;

    assign a1 = addr + 8'd1;
    assign a2 = addr + 8'd2;
    assign a3 = addr + 8'd3;

    always_ff @(posedge clk) begin
        if (load_en) IM[load_addr] <= load_dat;
    end

    assign instr = {IM[addr], IM[a1], IM[a2], IM[a3]};
endmodule

// Data store: combinational big-endian read, rising-edge store, stores suppressed during reset.
module mips_dmem #(
    parameter int BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdat,
    output logic [31:0] rdat
);
    logic [7:0] DM [0:BYTES-1];
    logic [7:0] a1, a2, a3;

    assign a1 = addr + 8'd1;
    assign a2 = addr + 8'd2;
    assign a3 = addr + 8'd3;

    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            DM[addr] <= wdat[31:24];
            DM[a1]   <= wdat[23:16];
            DM[a2]   <= wdat[15:8];
            DM[a3]   <= wdat[7:0];
        end
    end

    assign rdat = {DM[addr], DM[a1], DM[a2], DM[a3]};
endmodule

// Register file: two combinational reads, falling-edge write, $0 hardwired to zero.
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] RF [0:31];

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) RF[i] <= '0;
        end else if (we && wa != 5'd0) begin
            RF[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : RF[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : RF[ra2];
endmodule

// Decode, register file and ALU; drives DMEM address/data and the status outputs.
module mips_eu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] dm_rdat,
    output logic [7:0]  dm_addr,
    output logic [31:0] dm_wdat,
    output logic        dm_we,
    output logic [31:0] se_imm,
    output logic [25:0] jump_value,
    output logic        zero,
    output logic        branch,
    output logic        jump
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wr_reg;
    logic [31:0] rs_val, rt_val, alu_b, alu_res, wr_dat;
    alu_op_t     alu_op;
    logic        use_imm, rf_we, mem_to_reg, reg_dst_rd;

    assign opcode     = instr[31:26];
    assign rs         = instr[25:21];
    assign rt         = instr[20:16];
    assign rd         = instr[15:11];
    assign funct      = instr[5:0];
    assign se_imm     = {{16{instr[15]}}, instr[15:0]};
    assign jump_value = instr[25:0];
    assign branch     = (opcode == OP_BEQ);
    assign jump       = (opcode == OP_J);

    always_comb begin
        alu_op     = ALU_ADD;
        use_imm    = 1'b0;
        rf_we      = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst_rd = 1'b0;
        dm_we      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst_rd = 1'b1;
                rf_we      = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: rf_we  = 1'b0;
                endcase
            end
            OP_LW: begin
                use_imm    = 1'b1;
                rf_we      = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                use_imm = 1'b1;
                dm_we   = 1'b1;
            end
            OP_BEQ:  alu_op = ALU_SUB;
            default: ;
        endcase
    end

    assign alu_b = use_imm ? se_imm : rt_val;

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_res = rs_val - alu_b;
            ALU_AND: alu_res = rs_val & alu_b;
            ALU_OR:  alu_res = rs_val | alu_b;
            ALU_SLT: alu_res = {31'd0, $signed(rs_val) < $signed(alu_b)};
            default: alu_res = rs_val + alu_b;
        endcase
    end

    assign zero    = (alu_res == 32'd0);
    assign dm_addr = alu_res[7:0];
    assign dm_wdat = rt_val;
    assign wr_reg  = reg_dst_rd ? rd : rt;
    assign wr_dat  = mem_to_reg ? dm_rdat : alu_res;

    mips_regfile RF32 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (wr_reg),
        .wd    (wr_dat),
        .rd1   (rs_val),
        .rd2   (rt_val)
    );
endmodule

module mips_single_cycle_core #(
    parameter int IMEM_BYTES = 256,
    parameter int DMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ReadAddr,
    output logic [31:0] SEImm,
    output logic [25:0] JumpValue,
    output logic        Zero,
    output logic        Branch,
    output logic        Jump
);
    logic [31:0] instr, dm_rdat, dm_wdat;
    logic [7:0]  dm_addr;
    logic        dm_we;

    mips_imem #(.BYTES(IMEM_BYTES)) imem (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr (8'd0),
        .load_dat  (8'd0),
        .addr      (ReadAddr),
        .instr     (instr)
    );

    mips_eu eu (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .dm_rdat    (dm_rdat),
        .dm_addr    (dm_addr),
        .dm_wdat    (dm_wdat),
        .dm_we      (dm_we),
        .se_imm     (SEImm),
        .jump_value (JumpValue),
        .zero       (Zero),
        .branch     (Branch),
        .jump       (Jump)
    );

    mips_dmem #(.BYTES(DMEM_BYTES)) dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (dm_we),
        .addr  (dm_addr),
        .wdat  (dm_wdat),
        .rdat  (dm_rdat)
    );
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Bench for mips_single_cycle_core: directed program, random instruction stream, reset pulse,
// all checked against a behavioural model of registers and byte memories.
module tb_mips_single_cycle_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ReadAddr;
    logic [31:0] SEImm;
    logic [25:0] JumpValue;
    logic        Zero, Branch, Jump;

    mips_single_cycle_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ReadAddr  (ReadAddr),
        .SEImm     (SEImm),
        .JumpValue (JumpValue),
        .Zero      (Zero),
        .Branch    (Branch),
        .Jump      (Jump)
    );

    always #5 clk = ~clk;

    logic [7:0]  im_m [0:255];
    logic [7:0]  dm_m [0:255];
    logic [31:0] rf_m [0:31];
    int          total, bad;
    bit          pend_vld;
    int          pend_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int b);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w = {w[23:0], dm_m[(b + k) % 256]};
        return w;
    endfunction

    function automatic logic [31:0] dut_word(input int b);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w = {w[23:0], dut.dmem.DM[(b + k) % 256]};
        return w;
    endfunction

    function automatic logic [31:0] rand_instr();
        int         sel;
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        logic [15:0] imm;
        sel = $urandom_range(0, 8);
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 4))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            2:       fn = 6'h24;
            3:       fn = 6'h25;
            default: fn = 6'h2A;
        endcase
        case (sel)
            0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, fn};
            3:       return {6'h23, rs, rt, imm};
            4:       return {6'h2B, rs, rt, imm};
            5:       return {6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, imm};
            6:       return {6'h02, 26'($urandom)};
            7:       return {6'h00, rs, rt, rd, 5'd0, 6'h27};
            default: return {6'h0D, rs, rt, imm};
        endcase
    endfunction

    task automatic pend_check();
        if (pend_vld) begin
            chk("store_bytes", dut_word(pend_addr), m_word(pend_addr));
            pend_vld = 1'b0;
        end
    endtask

    // Presents one instruction, checks status before the falling edge and register state after it.
    task automatic exec(input int a);
        logic [31:0] ins, va, vb, sx, res;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        bit          zdef, rwr;
        ins = '0;
        for (int k = 0; k < 4; k++) ins = {ins[23:0], im_m[(a + k) % 256]};
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        sx = {{16{ins[15]}}, ins[15:0]};
        va = rf_m[rs];
        vb = rf_m[rt];
        zdef = 1'b1;
        rwr  = 1'b1;
        res  = '0;
        case (op)
            6'h00: case (fn)
                6'h20:   res = va + vb;
                6'h22:   res = va - vb;
                6'h24:   res = va & vb;
                6'h25:   res = va | vb;
                6'h2A:   res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                default: begin zdef = 1'b0; rwr = 1'b0; end
            endcase
            6'h23, 6'h2B: res = va + sx;
            6'h04:        begin res = va - vb; rwr = 1'b0; end
            default:      begin zdef = 1'b0; rwr = 1'b0; end
        endcase

        @(posedge clk);
        #1 ReadAddr = 8'(a);
        #2;
        pend_check();
        chk("seimm", SEImm, sx);
        chk("jumpvalue", {6'd0, JumpValue}, {6'd0, ins[25:0]});
        chk("branch", {31'd0, Branch}, {31'd0, op == 6'h04});
        chk("jump", {31'd0, Jump}, {31'd0, op == 6'h02});
        if (zdef) chk("zero", {31'd0, Zero}, {31'd0, res == 32'd0});

        if (op == 6'h00 && rwr && rd != 5'd0) rf_m[rd] = res;
        if (op == 6'h23 && rt != 5'd0) rf_m[rt] = m_word(res[7:0]);
        if (op == 6'h2B) begin
            for (int k = 0; k < 4; k++) dm_m[(int'(res[7:0]) + k) % 256] = vb[31 - 8 * k -: 8];
            pend_vld  = 1'b1;
            pend_addr = int'(res[7:0]);
        end

        #3;
        chk("rf_rt", dut.eu.RF32.RF[rt], rf_m[rt]);
        chk("rf_rd", dut.eu.RF32.RF[rd], rf_m[rd]);
    endtask

    logic [31:0] dir [0:6];
    logic [31:0] w, lw_exp;

    initial begin
        total = 0;
        bad = 0;
        pend_vld = 1'b0;
        pend_addr = 0;
        ReadAddr = 8'd196;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int i = 1; i < 32; i++) chk("reset_rf", dut.eu.RF32.RF[i], 32'd0);

        dir[0] = 32'h02CDF824; dir[1] = 32'h0043082A; dir[2] = 32'h8E8C0014;
        dir[3] = 32'hAC040000; dir[4] = 32'h10A6FFFF; dir[5] = 32'h01093822;
        dir[6] = 32'h08100004;
        for (int i = 0; i < 256; i++) begin
            im_m[i] = 8'($urandom);
            dm_m[i] = 8'($urandom);
        end
        for (int i = 0; i < 7; i++) for (int k = 0; k < 4; k++) im_m[4 * i + k] = dir[i][31 - 8 * k -: 8];
        for (int i = 0; i < 40; i++) begin
            w = rand_instr();
            for (int k = 0; k < 4; k++) im_m[28 + 4 * i + k] = w[31 - 8 * k -: 8];
        end
        for (int k = 0; k < 4; k++) begin
            w = 32'hAC0900FE; im_m[188 + k] = w[31 - 8 * k -: 8];
            w = 32'h8C0A00FE; im_m[192 + k] = w[31 - 8 * k -: 8];
            w = 32'hFC000000; im_m[196 + k] = w[31 - 8 * k -: 8];
            w = 32'hAC040010; im_m[200 + k] = w[31 - 8 * k -: 8];
            w = 32'h8C030014; im_m[204 + k] = w[31 - 8 * k -: 8];
        end
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'(i);
        for (int i = 0; i < 256; i++) begin
            dut.imem.IM[i] <= im_m[i];
            dut.dmem.DM[i] <= dm_m[i];
        end
        for (int i = 1; i < 32; i++) dut.eu.RF32.RF[i] <= 32'(i);

        exec(0);  chk("and_rf31", dut.eu.RF32.RF[31], 32'h00000004);
        exec(4);  chk("slt_rf1", dut.eu.RF32.RF[1], 32'h00000001);
        lw_exp = m_word(40);
        exec(8);  chk("lw_rf12", dut.eu.RF32.RF[12], lw_exp);
        exec(12);
        exec(16);
        chk("sw_dm0", dut_word(0), 32'h00000004);
        chk("beq_zero", {31'd0, Zero}, 32'd0);
        chk("beq_branch", {31'd0, Branch}, 32'd1);
        chk("beq_jump", {31'd0, Jump}, 32'd0);
        chk("beq_seimm", SEImm, 32'hFFFFFFFF);
        exec(20); chk("sub_rf7", dut.eu.RF32.RF[7], 32'hFFFFFFFF);
        exec(24);
        chk("j_jump", {31'd0, Jump}, 32'd1);
        chk("j_value", {6'd0, JumpValue}, 32'h00100004);

        for (int i = 0; i < 40; i++) exec(28 + 4 * i);
        exec(188);
        exec(192);
        exec(254);

        // Reset pulse in mid-cycle while a sw then a lw are presented.
        @(posedge clk);
        #1 ReadAddr = 8'd200;
        pend_check();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            chk("reset_mid_rf", dut.eu.RF32.RF[i], 32'd0);
            rf_m[i] = 32'd0;
        end
        @(posedge clk);
        #1 ReadAddr = 8'd204;
        #5;
        chk("reset_sw_blocked", dut_word(16), m_word(16));
        chk("reset_lw_blocked", dut.eu.RF32.RF[3], 32'd0);
        @(posedge clk);
        #1 ReadAddr = 8'd196;
        chk("reset_sw_blocked2", dut_word(16), m_word(16));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #6;
        for (int i = 0; i < 256; i += 4) chk("final_dm", dut_word(i), m_word(i));
        for (int i = 0; i < 32; i++) chk("final_rf", dut.eu.RF32.RF[i], rf_m[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
